// File: rtl/register_bist.sv
// Built-in self test for a simple load-enable register.
// Each vector from a synchronous ROM takes three cycles: fetch, apply, check.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; results of the last run are held
// FETCH  | vec_addr presents the current index to the ROM
// APPLY  | ROM word drives reg_in/reg_load; expected field is captured
// CHECK  | reg_out is compared to the captured expected value
// FINISH | done pulse; pass already reflects the completed run
module register_bist #(
  parameter int  WIDTH       = 16,
  parameter int  NUM_VECTORS = 150,
  localparam int VEC_W       = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       vec_addr,
  input  logic [VEC_W-1:0] vec_data,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_load,
  input  logic [WIDTH-1:0] reg_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_count,
  output logic [7:0]       first_fail_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, APPLY, CHECK, FINISH} state_t;

  state_t           state_q, state_d;
  logic [7:0]       index_q;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] exp_q;
  logic             last_vec;
  logic             mismatch;

  assign last_vec = (index_q == LAST_IDX);
  assign mismatch = (state_q == CHECK) && (reg_out != exp_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and the strobes that depend only on the current state.
  // reg_in follows the ROM combinationally in APPLY so the register under
  // test can sample it at the edge that ends APPLY; in CHECK it is held.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    reg_load = 1'b0;
    reg_in   = in_q;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: state_d = APPLY;
      APPLY: begin
        reg_in   = vec_data[VEC_W-1:WIDTH+1];
        reg_load = vec_data[WIDTH];
        state_d  = CHECK;
      end
      CHECK: state_d = last_vec ? FINISH : FETCH;
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector index, ROM address, captured fields and run results.
  // vec_addr is loaded on entry to FETCH so it is already valid during FETCH
  // and simply holds everywhere else. pass is resolved at the end of the final
  // CHECK so that it is valid during the FINISH cycle together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q        <= 8'd0;
      vec_addr       <= 8'd0;
      in_q           <= '0;
      exp_q          <= '0;
      fail_count     <= 8'd0;
      first_fail_idx <= 8'hFF;
      pass           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            index_q        <= 8'd0;
            vec_addr       <= 8'd0;
            fail_count     <= 8'd0;
            first_fail_idx <= 8'hFF;
            pass           <= 1'b0;
          end
        end
        APPLY: begin
          in_q  <= vec_data[VEC_W-1:WIDTH+1];
          exp_q <= vec_data[WIDTH-1:0];
        end
        CHECK: begin
          if (mismatch) begin
            if (fail_count != 8'hFF)     fail_count     <= fail_count + 8'd1;
            if (first_fail_idx == 8'hFF) first_fail_idx <= index_q;
          end
          if (last_vec) begin
            pass <= (fail_count == 8'd0) && !mismatch;
          end else begin
            index_q  <= index_q + 8'd1;
            vec_addr <= index_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_bist.sv
// Bench for register_bist: three instances (150, 255 and 1 vectors) each with
// its own synchronous ROM and register model; results are predicted by walking
// the vector list with plain arithmetic.
module tb_register_bist;

  localparam int W  = 16;
  localparam int VW = 2*W+1;

  typedef struct {
    int fails;
    int first;
    bit pass;
    int loads;
  } result_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance, 150 vectors, behavioural register
  logic          start_m = 1'b0;
  logic [7:0]    addr_m, fc_m, ffi_m;
  logic [VW-1:0] data_m = '0;
  logic [W-1:0]  in_m, out_m = '0;
  logic          load_m, busy_m, done_m, pass_m;
  logic [VW-1:0] rom_m [256];

  // saturation instance, 255 vectors, register output stuck at zero
  logic          start_s = 1'b0;
  logic [7:0]    addr_s, fc_s, ffi_s;
  logic [VW-1:0] data_s = '0;
  logic [W-1:0]  in_s;
  logic [W-1:0]  out_s;
  logic          load_s, busy_s, done_s, pass_s;
  logic [VW-1:0] rom_s [256];

  // single-vector instance
  logic          start_o = 1'b0;
  logic [7:0]    addr_o, fc_o, ffi_o;
  logic [VW-1:0] data_o = '0;
  logic [W-1:0]  in_o, out_o = '0;
  logic          load_o, busy_o, done_o, pass_o;
  logic [VW-1:0] rom_o [256];

  assign out_s = '0;

  register_bist #(.WIDTH(W), .NUM_VECTORS(150)) dut (
    .clk(clk), .reset(reset), .start(start_m), .vec_addr(addr_m), .vec_data(data_m),
    .reg_in(in_m), .reg_load(load_m), .reg_out(out_m), .busy(busy_m), .done(done_m),
    .pass(pass_m), .fail_count(fc_m), .first_fail_idx(ffi_m));

  register_bist #(.WIDTH(W), .NUM_VECTORS(255)) dut_sat (
    .clk(clk), .reset(reset), .start(start_s), .vec_addr(addr_s), .vec_data(data_s),
    .reg_in(in_s), .reg_load(load_s), .reg_out(out_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail_count(fc_s), .first_fail_idx(ffi_s));

  register_bist #(.WIDTH(W), .NUM_VECTORS(1)) dut_one (
    .clk(clk), .reset(reset), .start(start_o), .vec_addr(addr_o), .vec_data(data_o),
    .reg_in(in_o), .reg_load(load_o), .reg_out(out_o), .busy(busy_o), .done(done_o),
    .pass(pass_o), .fail_count(fc_o), .first_fail_idx(ffi_o));

  // synchronous ROMs and registers under test
  always @(posedge clk) begin
    data_m <= rom_m[addr_m];
    data_s <= rom_s[addr_s];
    data_o <= rom_o[addr_o];
    if (load_m) out_m <= in_m;
    if (load_o) out_o <= in_o;
  end

  // instance selector for the generic run task
  int sel = 0;
  logic       done_x, busy_x, pass_x, load_x;
  logic [7:0] fc_x, ffi_x;
  always_comb begin
    done_x = done_m; busy_x = busy_m; pass_x = pass_m; load_x = load_m; fc_x = fc_m; ffi_x = ffi_m;
    if (sel == 1) begin
      done_x = done_s; busy_x = busy_s; pass_x = pass_s; load_x = load_s; fc_x = fc_s; ffi_x = ffi_s;
    end else if (sel == 2) begin
      done_x = done_o; busy_x = busy_o; pass_x = pass_o; load_x = load_o; fc_x = fc_o; ffi_x = ffi_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_m = v;
    else if (which == 1) start_s = v;
    else start_o = v;
  endtask

  // Reference: walk the vectors in order, tracking what the register holds.
  function automatic result_t model(input logic [VW-1:0] rom [256], input int n, input bit stuck);
    result_t r;
    logic [W-1:0] held, seen;
    r.fails = 0; r.first = 255; r.loads = 0; held = '0;
    for (int i = 0; i < n; i++) begin
      if (rom[i][W]) begin
        held = rom[i][VW-1:W+1];
        r.loads++;
      end
      seen = stuck ? '0 : held;
      if (seen != rom[i][W-1:0]) begin
        if (r.first == 255) r.first = i;
        r.fails++;
      end
    end
    r.pass = (r.fails == 0);
    if (r.fails > 255) r.fails = 255;
    return r;
  endfunction

  // Random vectors consistent with a load-enable register; vector 0 always loads.
  task automatic fill_random();
    logic [W-1:0] held, din;
    logic ld;
    held = '0;
    for (int i = 0; i < 256; i++) begin
      ld  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      din = W'($urandom);
      if (din == 16'hDEAD) din = 16'hBEEF;
      if (ld) held = din;
      rom_m[i] = {din, ld, held};
    end
  endtask

  task automatic run_dut(input int which, input string name, input result_t exp, input int n);
    int cyc = 0;
    int loads = 0;
    int idle = 0;
    sel = which;
    set_start(which, 1'b1); step(); set_start(which, 1'b0);
    while (!done_x && cyc < 4000) begin
      step(); cyc++;
      if (load_x) loads++;
      if (!busy_x) idle++;
    end
    checks++; if (cyc !== 3*n) begin errors++; $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, 3*n); end
    checks++; if (pass_x !== exp.pass) begin errors++; $display("FAIL %s pass: got %0b expected %0b", name, pass_x, exp.pass); end
    checks++; if (fc_x !== 8'(exp.fails)) begin errors++; $display("FAIL %s fail_count: got %0d expected %0d", name, fc_x, exp.fails); end
    checks++; if (ffi_x !== 8'(exp.first)) begin errors++; $display("FAIL %s first_fail_idx: got %0d expected %0d", name, ffi_x, exp.first); end
    checks++; if (loads !== exp.loads) begin errors++; $display("FAIL %s load_pulses: got %0d expected %0d", name, loads, exp.loads); end
    checks++; if (idle !== 0) begin errors++; $display("FAIL %s busy_gap: got %0d idle cycles expected 0", name, idle); end
    step();
    checks++; if (busy_x !== 1'b0 || done_x !== 1'b0) begin errors++; $display("FAIL %s after_finish: got busy=%0b done=%0b expected 0 0", name, busy_x, done_x); end
    checks++; if (pass_x !== exp.pass || fc_x !== 8'(exp.fails)) begin errors++; $display("FAIL %s hold: got pass=%0b fc=%0d expected %0b %0d", name, pass_x, fc_x, exp.pass, exp.fails); end
  endtask

  task automatic test_reset();
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0 || pass_m !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%0b done=%0b pass=%0b expected 0 0 0", busy_m, done_m, pass_m); end
    checks++; if (fc_m !== 8'd0 || ffi_m !== 8'hFF) begin errors++; $display("FAIL reset_counts: got fc=%0h ffi=%0h expected 0 ff", fc_m, ffi_m); end
    checks++; if (load_m !== 1'b0 || in_m !== '0 || addr_m !== 8'd0) begin errors++; $display("FAIL reset_ports: got load=%0b in=%0h addr=%0h expected 0 0 0", load_m, in_m, addr_m); end
    checks++; if (ffi_s !== 8'hFF || ffi_o !== 8'hFF) begin errors++; $display("FAIL reset_others: got ffi_s=%0h ffi_o=%0h expected ff ff", ffi_s, ffi_o); end
    start_m = 1'b1; step();
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_priority: got busy=%0b expected 0", busy_m); end
    start_m = 1'b0; reset = 1'b0; step();
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_no_start: got busy=%0b expected 0", busy_m); end
  endtask

  task automatic test_clean_run();
    fill_random();
    run_dut(0, "clean", model(rom_m, 150, 1'b0), 150);
  endtask

  task automatic test_corrupt_7();
    fill_random();
    rom_m[7][W-1:0] = 16'hDEAD;
    run_dut(0, "corrupt7", model(rom_m, 150, 1'b0), 150);
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 3; r++) begin
      fill_random();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++)
        rom_m[$urandom_range(0, 149)][W-1:0] = W'($urandom);
      if (r == 2) rom_m[149][W-1:0] = ~rom_m[149][W-1:0];
      run_dut(0, "random_faults", model(rom_m, 150, 1'b0), 150);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) rom_s[i] = {W'($urandom), 1'($urandom_range(0, 1)), 16'hFFFF};
    run_dut(1, "saturate", model(rom_s, 255, 1'b1), 255);
  endtask

  task automatic test_single();
    rom_o[0] = {16'h1234, 1'b1, 16'h1234};
    run_dut(2, "single", model(rom_o, 1, 1'b0), 1);
  endtask

  task automatic test_reset_mid_run();
    result_t part;
    fill_random();
    rom_m[7][W-1:0] = 16'hDEAD;
    part = model(rom_m, 50, 1'b0);
    start_m = 1'b1; step(); start_m = 0;
    repeat (152) step();
    checks++; if (addr_m !== 8'd50) begin errors++; $display("FAIL midrun_addr: got %0d expected 50", addr_m); end
    checks++; if (fc_m !== 8'(part.fails)) begin errors++; $display("FAIL midrun_fc: got %0d expected %0d", fc_m, part.fails); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (busy_m !== 1'b0 || load_m !== 1'b0) begin errors++; $display("FAIL midrun_reset: got busy=%0b load=%0b expected 0 0", busy_m, load_m); end
    checks++; if (fc_m !== 8'd0 || ffi_m !== 8'hFF || addr_m !== 8'd0) begin errors++; $display("FAIL midrun_clear: got fc=%0h ffi=%0h addr=%0h expected 0 ff 0", fc_m, ffi_m, addr_m); end
    run_dut(0, "rerun", model(rom_m, 150, 1'b0), 150);
  endtask

  task automatic test_reset_apply();
    fill_random();
    start_m = 1'b1; step(); start_m = 1'b0;
    step();
    checks++; if (load_m !== 1'b1 || in_m !== rom_m[0][VW-1:W+1]) begin errors++; $display("FAIL apply_drive: got load=%0b in=%0h expected 1 %0h", load_m, in_m, rom_m[0][VW-1:W+1]); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (load_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL apply_reset: got load=%0b busy=%0b expected 0 0", load_m, busy_m); end
  endtask

  task automatic test_start_ignored();
    int cyc = 0;
    int dones = 0;
    int busy_cnt = 0;
    result_t exp;
    fill_random();
    exp = model(rom_m, 150, 1'b0);
    start_m = 1'b1; step(); start_m = 1'b0;
    while (!done_m && cyc < 2000) begin
      start_m = (cyc == 60);
      step(); cyc++;
      start_m = 1'b0;
    end
    checks++; if (cyc !== 450) begin errors++; $display("FAIL restart_latency: got %0d expected 450", cyc); end
    checks++; if (fc_m !== 8'(exp.fails) || pass_m !== exp.pass) begin errors++; $display("FAIL restart_result: got fc=%0d pass=%0b expected %0d %0b", fc_m, pass_m, exp.fails, exp.pass); end
    start_m = 1'b1; step(); start_m = 1'b0;
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL start_at_done: got busy=%0b done=%0b expected 0 0", busy_m, done_m); end
    repeat (10) begin
      step();
      if (done_m) dones++;
      if (busy_m) busy_cnt++;
    end
    checks++; if (dones !== 0 || busy_cnt !== 0) begin errors++; $display("FAIL single_done: got extra dones=%0d busy=%0d expected 0 0", dones, busy_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom_m[i] = '0; rom_s[i] = '0; rom_o[i] = '0;
    end
    reset = 1'b1;
    repeat (3) step();
    test_reset();
    test_clean_run();
    test_corrupt_7();
    test_random_faults();
    test_saturate();
    test_single();
    test_reset_apply();
    test_reset_mid_run();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bist.md
REGISTER_BIST -- requirements
Module: register_bist

Interface
REQ-001 Parameter WIDTH, default 16: data width of the register under test.
REQ-002 Parameter NUM_VECTORS, default 150: number of vectors per run, range 1..255.
REQ-003 Parameter VEC_W, fixed at 2*WIDTH+1 (33): vector word, packed {in[WIDTH-1:0], load, expected[WIDTH-1:0]} MSB first.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 vec_addr  output  8  vector ROM address.
REQ-008 vec_data  input  VEC_W  vector ROM data, valid the cycle after vec_addr is presented (synchronous ROM).
REQ-009 reg_in  output  WIDTH  data driven to the register under test.
REQ-010 reg_load  output  1  load strobe to the register under test.
REQ-011 reg_out  input  WIDTH  output of the register under test.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  one-cycle pulse when a run completes.
REQ-014 pass  output  1  high when the last completed run had zero mismatches.
REQ-015 fail_count  output  8  mismatch count of the current or last run, saturating at 255.
REQ-016 first_fail_idx  output  8  index of the first mismatching vector; 8'hFF when none.

Function
REQ-017 States: IDLE, FETCH, APPLY, CHECK, FINISH.
REQ-018 IDLE: start=1 -> FETCH; clears vector index to 0, fail_count to 0, first_fail_idx to 8'hFF, pass to 0; busy=1 from the next cycle.
REQ-019 FETCH (1 cycle): vec_addr = index; -> APPLY.
REQ-020 APPLY (1 cycle): reg_in = vec_data[VEC_W-1:WIDTH+1], reg_load = vec_data[WIDTH]; expected field captured internally; -> CHECK.
REQ-021 The register under test samples reg_in/reg_load at the rising edge that ends APPLY.
REQ-022 CHECK (1 cycle): reg_load = 0, reg_in holds its APPLY value; reg_out compared to the captured expected value.
REQ-023 Mismatch in CHECK: fail_count increments unless already 255; first_fail_idx takes index only if it is still 8'hFF.
REQ-024 CHECK exit: index == NUM_VECTORS-1 -> FINISH; otherwise index increments -> FETCH.
REQ-025 Throughput: exactly 3 cycles per vector; a run lasts 3*NUM_VECTORS cycles from the first FETCH to FINISH.
REQ-026 FINISH (1 cycle): done = 1; pass = (fail_count == 0 including any mismatch from the final CHECK); busy = 0 on the following cycle; -> IDLE.
REQ-027 pass, fail_count and first_fail_idx hold their values in IDLE until the next accepted start.
REQ-028 start is ignored whenever state is not IDLE; start and done in the same cycle does not start a new run.
REQ-029 reg_load = 0 in every state except APPLY.
REQ-030 vec_addr holds its last value outside FETCH.

Reset
REQ-031 reset=1 at a clock edge forces IDLE regardless of state, including mid-run.
REQ-032 Values after reset: busy=0, done=0, pass=0, fail_count=0, first_fail_idx=8'hFF, reg_load=0, reg_in=0, vec_addr=0, index=0.
REQ-033 reset has priority over start in the same cycle.
REQ-034 A reset during APPLY does not produce a reg_load pulse in the following cycle.

Verification
REQ-035 150-vector ROM matching a behavioural 16-bit register, start pulse -> done after 450 cycles, pass=1, fail_count=0, first_fail_idx=8'hFF.
REQ-036 Same ROM with vector 7 expected field corrupted to 16'hDEAD -> pass=0, fail_count=1, first_fail_idx=7.
REQ-037 Register-under-test model forcing reg_out=0 with all vectors expecting 16'hFFFF and NUM_VECTORS=255 -> fail_count=255 (saturated), first_fail_idx=0, pass=0.
REQ-038 reset asserted during CHECK of vector 50 -> next cycle busy=0, reg_load=0, fail_count=0; a later start re-runs from vec_addr=0.
REQ-039 start pulsed again at vector 20 of a run -> ignored, done still exactly 450 cycles after the first start, a single done pulse.
REQ-040 NUM_VECTORS=1, load=1, in=16'h1234, expected=16'h1234 -> done after 3 cycles, reg_load high for exactly 1 cycle, pass=1.
